// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read boot ROM between the fetch and load ports.
// It also range/alignment checks each access and extracts and extends load data on the response cycle.
module rom_port_arbiter #(
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_dout
);

  logic              w_gnt_i;
  logic              w_gnt_d;
  logic              w_i_err;
  logic              w_d_err;
  logic              w_d_align_err;
  logic [31:0]       w_i_data;
  logic [31:0]       w_d_data;
  logic [31:0]       w_d_ext;
  logic [7:0]        w_d_byte;
  logic [15:0]       w_d_half;
  logic [7:0]        w_lane [4];

  logic              r_last_data;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_i_pend;
  logic              r_i_err_q;
  logic              r_d_pend;
  logic              r_d_err_q;
  logic [1:0]        r_d_size;
  logic              r_d_uns;
  logic [1:0]        r_d_lsb;
  logic [31:0]       r_i_rdata;
  logic              r_i_err;
  logic [31:0]       r_d_rdata;
  logic              r_d_err;

  // The port that did not win last time takes a conflict; nothing is granted in reset.
  assign w_gnt_i = ~rst & i_req & (~d_req | r_last_data);
  assign w_gnt_d = ~rst & d_req & (~i_req | ~r_last_data);
  assign i_gnt   = w_gnt_i;
  assign d_gnt   = w_gnt_d;

  assign w_i_err = (i_addr[31:ADDR_W] != ROM_BASE[31:ADDR_W]) || (i_addr[1:0] != 2'b00);

  always_comb begin
    w_d_align_err = 1'b0;
    case (d_size)
      2'b00:   w_d_align_err = 1'b0;
      2'b01:   w_d_align_err = d_addr[0];
      2'b10:   w_d_align_err = (d_addr[1:0] != 2'b00);
      default: w_d_align_err = 1'b1;
    endcase
  end

  assign w_d_err = (d_addr[31:ADDR_W] != ROM_BASE[31:ADDR_W]) || w_d_align_err;

  // Error accesses never reach the ROM, so rom_addr only moves for a real read.
  always_comb begin
    rom_addr = r_rom_addr;
    if (w_gnt_i && !w_i_err) begin
      rom_addr = i_addr[ADDR_W-1:0];
    end else if (w_gnt_d && !w_d_err) begin
      rom_addr = d_addr[ADDR_W-1:0];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = rom_dout[8*gi +: 8];
  end

  assign w_d_byte = w_lane[r_d_lsb];
  assign w_d_half = r_d_lsb[1] ? rom_dout[31:16] : rom_dout[15:0];

  always_comb begin
    w_d_ext = rom_dout;
    case (r_d_size)
      2'b00:   w_d_ext = r_d_uns ? {24'h0, w_d_byte} : {{24{w_d_byte[7]}}, w_d_byte};
      2'b01:   w_d_ext = r_d_uns ? {16'h0, w_d_half} : {{16{w_d_half[15]}}, w_d_half};
      default: w_d_ext = rom_dout;
    endcase
  end

  assign w_i_data = r_i_err_q ? 32'h0 : rom_dout;
  assign w_d_data = r_d_err_q ? 32'h0 : w_d_ext;

  // Responses are live on the cycle ROM data arrives; otherwise the last response is held.
  assign i_rvalid = r_i_pend & ~rst;
  assign d_rvalid = r_d_pend & ~rst;
  assign i_rdata  = i_rvalid ? w_i_data  : r_i_rdata;
  assign i_err    = i_rvalid ? r_i_err_q : r_i_err;
  assign d_rdata  = d_rvalid ? w_d_data  : r_d_rdata;
  assign d_err    = d_rvalid ? r_d_err_q : r_d_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_data <= 1'b1;
      r_rom_addr  <= '0;
      r_i_pend    <= 1'b0;
      r_i_err_q   <= 1'b0;
      r_d_pend    <= 1'b0;
      r_d_err_q   <= 1'b0;
      r_d_size    <= 2'b00;
      r_d_uns     <= 1'b0;
      r_d_lsb     <= 2'b00;
      r_i_rdata   <= 32'h0;
      r_i_err     <= 1'b0;
      r_d_rdata   <= 32'h0;
      r_d_err     <= 1'b0;
    end else begin
      r_rom_addr <= rom_addr;
      r_i_pend   <= w_gnt_i;
      r_d_pend   <= w_gnt_d;
      if (w_gnt_i) begin
        r_last_data <= 1'b0;
      end else if (w_gnt_d) begin
        r_last_data <= 1'b1;
      end
      if (w_gnt_i) begin
        r_i_err_q <= w_i_err;
      end
      if (w_gnt_d) begin
        r_d_err_q <= w_d_err;
        r_d_size  <= d_size;
        r_d_uns   <= d_unsigned;
        r_d_lsb   <= d_addr[1:0];
      end
      if (i_rvalid) begin
        r_i_rdata <= w_i_data;
        r_i_err   <= r_i_err_q;
      end
      if (d_rvalid) begin
        r_d_rdata <= w_d_data;
        r_d_err   <= r_d_err_q;
      end
    end
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port, synchronous-read boot ROM between the core's instruction-fetch port and its data-load port.
- The ROM is 256 x 32, word-indexed by rom_addr[9:2], with dout registered one cycle after the address is presented.
- Arbitration is round-robin per cycle. Each port gets a response aligned to the ROM's 1-cycle latency.
- The block also does address-range checking and byte/halfword extraction for data loads.
- Sits between the core's fetch/LSU ports and the rom instance in the SoC.

Parameters:
- ROM_BASE, 32'h0000_0000, byte base address of the ROM window.
- ADDR_W, 10, byte-address width of the ROM window (window size = 2**ADDR_W bytes).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch request accepted this cycle (combinational).
- i_rvalid  out  1  fetch response valid (1-cycle pulse).
- i_rdata  out  32  fetch word.
- i_err  out  1  fetch error, qualified by i_rvalid.
- d_req  in  1  load request.
- d_addr  in  32  load byte address.
- d_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- d_unsigned  in  1  zero-extend when 1, sign-extend when 0.
- d_gnt  out  1  load request accepted this cycle (combinational).
- d_rvalid  out  1  load response valid (1-cycle pulse).
- d_rdata  out  32  extracted and extended load data.
- d_err  out  1  load error, qualified by d_rvalid.
- rom_addr  out  10  address to the ROM.
- rom_dout  in  32  ROM read data, valid the cycle after rom_addr.

Behaviour:
- Reset values (one cycle after rst high):
  - i_rvalid, d_rvalid, i_err, d_err = 0.
  - i_rdata, d_rdata = 0.
  - Round-robin pointer set to last_grant = DATA, so the fetch port wins the first conflict.
- Arbitration (combinational in cycle T):
  - Only one requester active → it is granted.
  - Both active → the port not granted last is granted.
  - last_grant updates only on a grant.
  - i_gnt and d_gnt are never both 1.
- A requester holds req and addr stable until gnt. After gnt it may issue a new request the next cycle; back-to-back grants every cycle are supported.
- rom_addr:
  - Driven with addr[ADDR_W-1:0] of the granted port.
  - Holds its previous value when nothing is granted (no spurious toggling).
- Response timing: granted in cycle T → rvalid=1 in cycle T+1 on the same port's output. Latency is exactly 1, with no extra buffering.
- rdata/err persistence: rdata and err hold their last response value when rvalid=0; they are only overwritten on the next response for that port.
- Range check: addr[31:ADDR_W] != ROM_BASE[31:ADDR_W] → error response. For an error response:
  - Granted normally, with rvalid at T+1.
  - err=1 and rdata=0.
  - ROM output ignored.
- Fetch alignment: i_addr[1:0] != 0 → err=1.
- Data alignment:
  - Illegal d_size=11 → err=1.
  - Half with d_addr[0]=1 → err=1.
  - Word with d_addr[1:0] != 0 → err=1.
- Per-port state registered at grant for use at T+1: granted-port id, err flag, size, unsigned, addr[1:0].
- Data extraction at T+1:
  - Byte: lane addr[1:0]; lane 0 = rom_dout[7:0] (little-endian).
  - Half: addr[1]=0 → [15:0]; addr[1]=1 → [31:16].
  - Word: unchanged.
  - Sign- or zero-extend per the registered d_unsigned.
- Fetch data: i_rdata = rom_dout unmodified.
- Reset mid-transaction: rst in cycle T+1 of an in-flight access:
  - rvalid=0 in that cycle; the response is dropped.
  - Pointer re-initialised.
  - No response is ever produced for a request granted before reset.
- Granting while rst=1: rst has priority; no grants are issued while rst=1.

Test Plan:
- Test ROM model: word0 = 32'h00000093, word99 = 32'h6C6C6548.
- Scenarios:
  - Single fetch: i_req with i_addr=0 → i_gnt same cycle; i_rvalid next cycle with i_rdata=32'h00000093 and i_err=0; d_rvalid stays 0.
  - Conflict after reset: i_req and d_req held high together for 4 cycles, d_addr=0x18C word → grants alternate I,D,I,D; d_rdata=32'h6C6C6548 on each D response.
  - Byte loads at 0x18C..0x18F, unsigned → d_rdata = 0x48, 0x65, 0x6C, 0x6C. Half at 0x18E, signed → 0x00006C6C.
  - Sign extension: model word100 = 32'h726F57EF; byte load at 0x190 → signed 0xFFFFFFEF, unsigned 0x000000EF.
  - Errors (each gets rvalid next cycle with err=1, rdata=0; rom_addr unchanged if nothing else is granted):
    - d_addr=0x1000_0004.
    - Half at 0x001.
    - d_size=11.
    - i_addr=0x002.
  - Reset mid-access: grant D at T, rst=1 at T+1 → d_rvalid=0 at T+1 and T+2. First conflict after reset grants the fetch port.
